mix_sink: RTL and testbench

MIX_SINK -- requirements
Module: mix_sink

---
 rtl/mix_pkg.sv | 27 ++
 rtl/mix_sink_fifo.sv | 87 ++++++++
 rtl/mix_sink.sv | 85 ++++++++
 tb/tb_mix_sink.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared definitions for the mix_sink buffer: counter width, clog2 helper
// and the per-cycle buffer operation encoding.
package mix_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } fifo_op_e;

  // Ceiling log2; callers guarantee value >= 2.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mix_sink_fifo.sv
// Register-based circular buffer for mix_sink: storage, wrapping pointers and
// occupancy. The head entry is read straight from the storage registers.
module mix_sink_fifo
  import mix_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [clog2(DEPTH):0]  level
);

  localparam int PW = clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  fifo_op_e         op;

  // Never write when full or read when empty, even if the caller misbehaves.
  assign push_ok = push && (level != FULL_LVL);
  assign pop_ok  = pop && (level != '0);

  always_comb begin
    op = OP_IDLE;
    if (push_ok && pop_ok) begin
      op = OP_BOTH;
    end else if (push_ok) begin
      op = OP_PUSH;
    end else if (pop_ok) begin
      op = OP_POP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clear && push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_ptr <= wr_ptr + PW'(1);
          level  <= level + LW'(1);
        end
        OP_POP: begin
          rd_ptr <= rd_ptr + PW'(1);
          level  <= level - LW'(1);
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + PW'(1);
          rd_ptr <= rd_ptr + PW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mix_sink.sv
// Byte sink with buffering, accepted-byte counter and sticky overflow flag.
// Define MIX_SINK_CHECKSUM_EN to build the running 16-bit checksum; otherwise csum is 0.
module mix_sink
  import mix_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clear,
  output logic [clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]       byte_cnt,
  output logic [CNT_W-1:0]       csum,
  output logic                   overflow
);

  localparam int LW = clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic push;
  logic pop;

  // Handshakes derive only from registered level, so in_ready ignores out_ready.
  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  mix_sink_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (out_data),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef MIX_SINK_CHECKSUM_EN
  logic [CNT_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (clear) begin
      csum_q <= '0;
    end else if (push) begin
      csum_q <= csum_q + CNT_W'(in_data);
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_mix_sink.sv
// Directed self-checking bench for mix_sink (WIDTH=8, DEPTH=4); expected csum
// follows whether MIX_SINK_CHECKSUM_EN is defined.
module tb_mix_sink;

`ifdef MIX_SINK_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clear;
  logic [2:0]  level;
  logic [15:0] byte_cnt;
  logic [15:0] csum;
  logic        overflow;

  int testCount;
  int failCount;

  mix_sink #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clear     (clear),
    .level     (level),
    .byte_cnt  (byte_cnt),
    .csum      (csum),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expCsum(input logic [15:0] sum);
    return CSUM_EN ? {16'h0, sum} : 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic rdy, input logic clr);
    in_valid  = valid;
    in_data   = data;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_level"},    32'(level),     32'd0);
    checkOutput({tag, "_outvalid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_inready"},  32'(in_ready),  32'd1);
    checkOutput({tag, "_outdata"},  32'(out_data),  32'd0);
    checkOutput({tag, "_bytecnt"},  32'(byte_cnt),  32'd0);
    checkOutput({tag, "_csum"},     32'(csum),      32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow),  32'd0);
  endtask

  logic [7:0] drainExp [4];

  initial begin
    testCount = 0;
    failCount = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    clear     = 1'b0;
    drainExp  = '{8'h11, 8'h22, 8'h33, 8'h44};

    #3;
    checkReset("por");
    @(negedge clk);
    rst = 1'b1;

    // First-byte latency and basic fill
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("first_outvalid", 32'(out_valid), 32'd1);
    checkOutput("first_outdata",  32'(out_data),  32'h11);
    checkOutput("first_level",    32'(level),     32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("fill3_level",   32'(level),    32'd3);
    checkOutput("fill3_outdata", 32'(out_data), 32'h11);
    checkOutput("fill3_bytecnt", 32'(byte_cnt), 32'd3);
    checkOutput("fill3_csum",    32'(csum),     expCsum(16'h0066));

    // Fill to DEPTH, then attempt a fifth push
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("full_level",    32'(level),    32'd4);
    checkOutput("full_inready",  32'(in_ready), 32'd0);
    checkOutput("full_overflow", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("ovf_level",    32'(level),    32'd4);
    checkOutput("ovf_flag",     32'(overflow), 32'd1);
    checkOutput("ovf_bytecnt",  32'(byte_cnt), 32'd4);
    checkOutput("ovf_csum",     32'(csum),     expCsum(16'h00AA));
    checkOutput("ovf_outdata",  32'(out_data), 32'h11);

    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_data", 32'(out_data), 32'(drainExp[i]));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drain_level",    32'(level),     32'd0);
    checkOutput("drain_outvalid", 32'(out_valid), 32'd0);
    checkOutput("drain_overflow", 32'(overflow),  32'd1);

    // Pop requests against an empty buffer
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("empty_outvalid", 32'(out_valid), 32'd0);
      checkOutput("empty_level",    32'(level),     32'd0);
      checkOutput("empty_bytecnt",  32'(byte_cnt),  32'd4);
    end

    // Clear with concurrent push and pop at level 3
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    checkOutput("preclr_level",   32'(level),    32'd3);
    checkOutput("preclr_bytecnt", 32'(byte_cnt), 32'd7);
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b1);
    checkOutput("clr_level",    32'(level),     32'd0);
    checkOutput("clr_bytecnt",  32'(byte_cnt),  32'd0);
    checkOutput("clr_csum",     32'(csum),      32'd0);
    checkOutput("clr_overflow", 32'(overflow),  32'd0);
    checkOutput("clr_inready",  32'(in_ready),  32'd1);
    checkOutput("clr_outvalid", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at level 2
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
    checkOutput("pp_prelevel", 32'(level),    32'd2);
    checkOutput("pp_predata",  32'(out_data), 32'h10);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("pp_level",   32'(level),    32'd2);
    checkOutput("pp_data",    32'(out_data), 32'h20);
    checkOutput("pp_bytecnt", 32'(byte_cnt), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pp_last_data",  32'(out_data), 32'hAA);
    checkOutput("pp_last_level", 32'(level),    32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("pp_csum", 32'(csum), expCsum(16'h00DA));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pp_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle with data buffered
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
    checkOutput("prerst_level", 32'(level), 32'd2);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkReset("async");
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("inrst_level", 32'(level), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("post_outdata",  32'(out_data),  32'h5A);
    checkOutput("post_outvalid", 32'(out_valid), 32'd1);
    checkOutput("post_level",    32'(level),     32'd1);
    checkOutput("post_bytecnt",  32'(byte_cnt),  32'd1);
    checkOutput("post_csum",     32'(csum),      expCsum(16'h005A));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
